// File: rtl/pcpi_if.sv
// pcpi_if: PCPI instruction/result bundle between a core and a coprocessor.
interface pcpi_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/pcpi_muldiv_iter.sv
// pcpi_muldiv_iter: iterative RV32M multiply/divide coprocessor on the PCPI port.
// Works on operand magnitudes; the sign is applied when the result is registered.
module pcpi_muldiv_iter #(
  parameter int unsigned MUL_STEP   = 4,
  parameter bit          ENABLE_DIV = 1'b1
) (
  input  logic  clk,
  input  logic  resetn,
  pcpi_if.slave pcpi
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 6;
  localparam logic [CW-1:0] MUL_ITERS = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0] DIV_ITERS = CW'(XLEN);

  // Reject multiply radices that do not evenly tile a 32-bit operand.
  generate
    if (MUL_STEP != 1 && MUL_STEP != 2 && MUL_STEP != 4 &&
        MUL_STEP != 8 && MUL_STEP != 16 && MUL_STEP != 32) begin : g_bad_step
      $error("pcpi_muldiv_iter: MUL_STEP must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic [XLEN-1:0]   rs1_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   dvsr;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   rd_q;
  logic              ready_q;
  logic              wait_q;

  logic [2:0]        f3_in;
  logic              rs1_neg, rs2_neg, neg_in, accept;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN:0]     rem_sh, rem_sub;
  logic              q_bit;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, res;

  assign pcpi.pcpi_rd    = rd_q;
  assign pcpi.pcpi_ready = ready_q;
  assign pcpi.pcpi_wr    = ready_q;
  assign pcpi.pcpi_wait  = wait_q;

  // Decode of the presented instruction and operand magnitudes/sign.
  always_comb begin
    f3_in   = pcpi.pcpi_insn[14:12];
    rs1_neg = pcpi.pcpi_rs1[XLEN-1] &&
              (f3_in == 3'b001 || f3_in == 3'b010 || f3_in == 3'b100 || f3_in == 3'b110);
    rs2_neg = pcpi.pcpi_rs2[XLEN-1] &&
              (f3_in == 3'b001 || f3_in == 3'b100 || f3_in == 3'b110);
    mag1    = rs1_neg ? -pcpi.pcpi_rs1 : pcpi.pcpi_rs1;
    mag2    = rs2_neg ? -pcpi.pcpi_rs2 : pcpi.pcpi_rs2;
    neg_in  = (f3_in[2:1] == 2'b11) ? rs1_neg : (rs1_neg ^ rs2_neg);
    accept  = pcpi.pcpi_valid &&
              pcpi.pcpi_insn[6:0] == 7'b0110011 &&
              pcpi.pcpi_insn[31:25] == 7'b0000001 &&
              (!pcpi.pcpi_insn[14] || ENABLE_DIV);
  end

  // One multiply/divide iteration and the sign-corrected result it would give.
  always_comb begin
    acc_nxt = acc + mcand * 64'(mplier[MUL_STEP-1:0]);
    rem_sh  = {rem, quo[XLEN-1]};
    rem_sub = rem_sh - {1'b0, dvsr};
    q_bit   = ~rem_sub[XLEN];
    rem_nxt = q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], q_bit};
    prod    = neg_q ? -acc_nxt : acc_nxt;
    if (state == S_MUL) begin
      res = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (dvsr == '0) begin
      res = f3[1] ? rs1_q : '1;
    end else if (f3[1]) begin
      res = neg_q ? -rem_nxt : rem_nxt;
    end else begin
      res = neg_q ? -quo_nxt : quo_nxt;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      f3      <= '0;
      rs1_q   <= '0;
      neg_q   <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      dvsr    <= '0;
      quo     <= '0;
      rem     <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            f3     <= f3_in;
            rs1_q  <= pcpi.pcpi_rs1;
            neg_q  <= neg_in;
            wait_q <= 1'b1;
            if (f3_in[2]) begin
              state <= S_DIV;
              cnt   <= DIV_ITERS;
              quo   <= mag1;
              rem   <= '0;
              dvsr  <= mag2;
            end else begin
              state  <= S_MUL;
              cnt    <= MUL_ITERS;
              acc    <= '0;
              mcand  <= {{XLEN{1'b0}}, mag1};
              mplier <= mag2;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (!pcpi.pcpi_valid) begin
            state  <= S_IDLE;
            wait_q <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
            if (state == S_MUL) begin
              acc    <= acc_nxt;
              mcand  <= mcand << MUL_STEP;
              mplier <= mplier >> MUL_STEP;
            end else begin
              rem <= rem_nxt;
              quo <= quo_nxt;
            end
            if (cnt == CW'(1)) begin
              state   <= S_DONE;
              rd_q    <= res;
              ready_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          wait_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          wait_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pcpi_muldiv_iter.sv
// tb_pcpi_muldiv_iter: directed and randomised checks of pcpi_muldiv_iter in four
// configurations against a plain-arithmetic RV32M reference model.
module tb_pcpi_muldiv_iter;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        valid;
  logic [31:0] insn, rs1, rs2;
  int          sel;

  // 0: step 4, 1: step 1, 2: step 32, 3: step 4 without divider
  pcpi_if bus0 ();
  pcpi_if bus1 ();
  pcpi_if bus2 ();
  pcpi_if bus3 ();

  assign bus0.pcpi_valid = valid && (sel == 0);
  assign bus1.pcpi_valid = valid && (sel == 1);
  assign bus2.pcpi_valid = valid && (sel == 2);
  assign bus3.pcpi_valid = valid && (sel == 3);
  assign bus0.pcpi_insn = insn; assign bus0.pcpi_rs1 = rs1; assign bus0.pcpi_rs2 = rs2;
  assign bus1.pcpi_insn = insn; assign bus1.pcpi_rs1 = rs1; assign bus1.pcpi_rs2 = rs2;
  assign bus2.pcpi_insn = insn; assign bus2.pcpi_rs1 = rs1; assign bus2.pcpi_rs2 = rs2;
  assign bus3.pcpi_insn = insn; assign bus3.pcpi_rs1 = rs1; assign bus3.pcpi_rs2 = rs2;

  pcpi_muldiv_iter #(.MUL_STEP(4),  .ENABLE_DIV(1'b1)) u0 (.clk(clk), .resetn(resetn), .pcpi(bus0));
  pcpi_muldiv_iter #(.MUL_STEP(1),  .ENABLE_DIV(1'b1)) u1 (.clk(clk), .resetn(resetn), .pcpi(bus1));
  pcpi_muldiv_iter #(.MUL_STEP(32), .ENABLE_DIV(1'b1)) u2 (.clk(clk), .resetn(resetn), .pcpi(bus2));
  pcpi_muldiv_iter #(.MUL_STEP(4),  .ENABLE_DIV(1'b0)) u3 (.clk(clk), .resetn(resetn), .pcpi(bus3));

  logic [3:0]  rdy_v, wr_v, wt_v;
  logic [31:0] rd_v [4];
  assign rdy_v = {bus3.pcpi_ready, bus2.pcpi_ready, bus1.pcpi_ready, bus0.pcpi_ready};
  assign wr_v  = {bus3.pcpi_wr, bus2.pcpi_wr, bus1.pcpi_wr, bus0.pcpi_wr};
  assign wt_v  = {bus3.pcpi_wait, bus2.pcpi_wait, bus1.pcpi_wait, bus0.pcpi_wait};
  assign rd_v[0] = bus0.pcpi_rd;
  assign rd_v[1] = bus1.pcpi_rd;
  assign rd_v[2] = bus2.pcpi_rd;
  assign rd_v[3] = bus3.pcpi_rd;

  // Model state: the one outstanding operation and each unit's last result.
  bit          act;
  int          t_acc, t_rdy, t_abort;
  logic [31:0] exp_rd;
  logic [31:0] mdl_rd [4];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] xs_state;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int step_of(input int k);
    return (k == 1) ? 1 : (k == 2) ? 32 : 4;
  endfunction

  function automatic logic [31:0] mk_insn(input logic [6:0] funct7, input logic [2:0] f3);
    return {funct7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      p;
    logic [63:0] u;
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] xs();
    xs_state = xs_state ^ (xs_state << 13);
    xs_state = xs_state ^ (xs_state >> 17);
    xs_state = xs_state ^ (xs_state << 5);
    return xs_state;
  endfunction

  // Per-cycle comparison of every unit against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      bit mine, w_exp, r_exp;
      if (!resetn) begin
        mdl_rd[k] = 32'd0;
        w_exp = 1'b0;
        r_exp = 1'b0;
      end else begin
        mine  = act && (sel == k);
        w_exp = mine && cyc > t_acc && cyc <= t_rdy && cyc <= t_abort;
        r_exp = mine && cyc == t_rdy && cyc <= t_abort;
        if (r_exp) mdl_rd[k] = exp_rd;
      end
      chk($sformatf("wait%0d", k), 32'(wt_v[k]), 32'(w_exp));
      chk($sformatf("ready%0d", k), 32'(rdy_v[k]), 32'(r_exp));
      chk($sformatf("wr%0d", k), 32'(wr_v[k]), 32'(r_exp));
      chk($sformatf("rd%0d", k), rd_v[k], mdl_rd[k]);
    end
  end

  // Issue one instruction to unit k; optional valid drop or reset at an offset from accept.
  task automatic run_op(input int k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input bit use_lit, input int drop_at, input int rst_at);
    sel     = k;
    insn    = mk_insn(7'b0000001, f3);
    rs1     = a;
    rs2     = b;
    valid   = 1'b1;
    exp_rd  = ref_op(f3, a, b);
    t_acc   = cyc;
    t_rdy   = cyc + (f3[2] ? 33 : 1 + 32 / step_of(k));
    t_abort = 32'h7FFF_FFFF;
    act     = 1'b1;
    if (use_lit) chk($sformatf("model_f3_%0d", f3), exp_rd, lit);
    while (cyc <= t_rdy) begin
      @(posedge clk); #1;
      if (use_lit && cyc == t_rdy) chk($sformatf("rd_lit%0d", k), rd_v[k], lit);
      if (drop_at >= 0 && cyc == t_acc + drop_at) begin
        valid   = 1'b0;
        t_abort = cyc;
      end
      if (rst_at >= 0 && cyc == t_acc + rst_at) begin
        resetn = 1'b0;
        valid  = 1'b0;
        act    = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
          chk($sformatf("rst_out%0d", j), {rd_v[j][28:0], wt_v[j], rdy_v[j], wr_v[j]}, 32'd0);
          chk($sformatf("rst_rdhi%0d", j), 32'(rd_v[j][31:29]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        break;
      end
    end
    valid = 1'b0;
    act   = 1'b0;
    @(posedge clk); #1;
  endtask

  // Hold an undecodable/disabled instruction valid; every unit must stay quiet.
  task automatic hold_ignored(input int k, input logic [31:0] word, input int ncyc);
    sel   = k;
    insn  = word;
    rs1   = 32'd100;
    rs2   = 32'd7;
    act   = 1'b0;
    valid = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    resetn  = 1'b0;
    valid   = 1'b0;
    insn    = '0;
    rs1     = '0;
    rs2     = '0;
    sel     = 0;
    act     = 1'b0;
    t_acc   = 0;
    t_rdy   = 0;
    t_abort = 0;
    exp_rd  = '0;
    for (int k = 0; k < 4; k++) mdl_rd[k] = '0;
    xs_state = 32'h2545_F491 ^ $urandom();
    if (xs_state == 32'd0) xs_state = 32'h1;

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    run_op(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, -1, -1);
    for (int k = 0; k < 3; k++) begin
      run_op(k, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, -1, -1);
      run_op(k, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, -1, -1);
      run_op(k, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, -1);
    end

    run_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, -1, -1);
    run_op(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, -1, -1);
    run_op(0, 3'b101, 32'd100, 32'd7, 32'd14, 1'b1, -1, -1);
    run_op(0, 3'b111, 32'd100, 32'd7, 32'd2, 1'b1, -1, -1);
    run_op(0, 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, -1, -1);
    run_op(0, 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, -1, -1);
    run_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1, -1);
    run_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, -1, -1);

    hold_ignored(0, mk_insn(7'b0000000, 3'b000), 40);
    hold_ignored(3, mk_insn(7'b0000001, 3'b100), 40);

    run_op(0, 3'b100, 32'd1234, 32'd5, 32'd0, 1'b0, 5, -1);
    run_op(0, 3'b000, 32'd99, 32'd99, 32'd0, 1'b0, -1, 3);
    run_op(0, 3'b000, 32'd3, 32'd4, 32'd12, 1'b1, -1, -1);

    for (int i = 0; i < 100; i++) begin
      logic [31:0] r, a, b;
      r = xs();
      case (r[2:0])
        3'd0: a = 32'd0;
        3'd1: a = 32'hFFFF_FFFF;
        3'd2: a = 32'h8000_0000;
        3'd3: a = 32'(r[7:4]);
        default: a = xs();
      endcase
      case (r[10:8])
        3'd0: b = 32'd0;
        3'd1: b = 32'hFFFF_FFFF;
        3'd2: b = 32'h8000_0000;
        3'd3: b = 32'(r[15:12]);
        default: b = xs();
      endcase
      run_op(i % 3, 3'(i), a, b, 32'd0, 1'b0, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
